// File: rtl/n_bit_subtractor.sv
// Pipelined ripple-borrow subtractor: diff = a - b - bin, one difference bit resolved per stage.
// Valid/ready flow control lets each empty stage refill even while the stages after it are stalled.
module n_bit_subtractor_stage #(
  parameter int WIDTH = 8,
  parameter int K     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               load,
  input  logic               v_in,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-K-1:0] b_in,
  input  logic               br_in,
  input  logic               am_in,
  output logic               v,
  output logic               am,
  output logic [WIDTH-K-1:0] b_q,
  output logic [WIDTH-1:0]   a_nx,
  output logic               br_nx
);
  logic [WIDTH-1:0] a_q;
  logic             br_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v    <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
      br_q <= 1'b0;
      am   <= 1'b0;
    end else begin
      if (flush)     v <= 1'b0;
      else if (load) v <= v_in;
      if (load) begin
        a_q  <= a_in;
        b_q  <= b_in;
        br_q <= br_in;
        am   <= am_in;
      end
    end
  end

  // Full-subtractor cell for bit K; the difference bit overwrites a_K on its way down the pipe.
  always_comb begin
    a_nx    = a_q;
    a_nx[K] = a_q[K] ^ b_q[0] ^ br_q;
    br_nx   = (~a_q[K] & b_q[0]) | (~(a_q[K] ^ b_q[0]) & br_q);
  end
endmodule

module n_bit_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);
  logic [WIDTH-1:0] v;
  logic [WIDTH:0]   rdy;

  assign rdy[WIDTH] = out_ready;
  assign in_ready   = rdy[0];

  for (genvar k = 0; k < WIDTH; k++) begin : g_st
    logic [WIDTH-k-1:0] b_q;
    logic [WIDTH-k-1:0] b_in;
    logic [WIDTH-1:0]   a_nx;
    logic [WIDTH-1:0]   a_in;
    logic               br_nx, am, v_in, br_in, am_in;

    assign rdy[k] = ~v[k] | rdy[k+1];

    if (k == 0) begin : g_head
      assign v_in  = in_valid;
      assign a_in  = a;
      assign b_in  = b;
      assign br_in = bin;
      assign am_in = a[WIDTH-1];
    end else begin : g_body
      // b shrinks by one bit per stage: bits already consumed are not carried forward.
      assign v_in  = v[k-1];
      assign a_in  = g_st[k-1].a_nx;
      assign b_in  = g_st[k-1].b_q[WIDTH-k:1];
      assign br_in = g_st[k-1].br_nx;
      assign am_in = g_st[k-1].am;
    end

    n_bit_subtractor_stage #(.WIDTH(WIDTH), .K(k)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .load  (rdy[k]),
      .v_in  (v_in),
      .a_in  (a_in),
      .b_in  (b_in),
      .br_in (br_in),
      .am_in (am_in),
      .v     (v[k]),
      .am    (am),
      .b_q   (b_q),
      .a_nx  (a_nx),
      .br_nx (br_nx)
    );
  end

  logic [WIDTH-1:0] d_raw;
  logic             bo_raw, a_msb, b_msb;

  assign d_raw  = g_st[WIDTH-1].a_nx;
  assign bo_raw = g_st[WIDTH-1].br_nx;
  assign a_msb  = g_st[WIDTH-1].am;
  assign b_msb  = g_st[WIDTH-1].b_q[0];

  // Gate everything with out_valid so stale data left by a flush or drain never shows.
  assign out_valid = v[WIDTH-1];
  assign diff      = out_valid ? d_raw : '0;
  assign bout      = out_valid & bo_raw;
  assign zero      = out_valid & (d_raw == '0);
  assign ovf       = out_valid & (a_msb ^ b_msb) & (d_raw[WIDTH-1] ^ a_msb);
endmodule

// File: tb/tb_n_bit_subtractor.sv
// Scoreboard bench for n_bit_subtractor: expected results queued on accept, popped by a monitor.
module tb_n_bit_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0, rst = 1'b0, flush = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b1, bin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, bout, zero, ovf;
  logic [W-1:0] diff;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf;
  } res_t;

  res_t exp_q[$];
  int   checks = 0, failures = 0, n_out = 0;

  n_bit_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, expv);
    end
  endtask

  // Reference: widened unsigned subtract for diff/borrow, exact signed result for overflow.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] t;
    int         s;
    res_t       r;
    t      = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
    s      = int'($signed(x)) - int'($signed(y)) - int'(c);
    r.diff = t[W-1:0];
    r.bout = t[W];
    r.zero = (t[W-1:0] == '0);
    r.ovf  = (s > (2**(W-1) - 1)) || (s < -(2**(W-1)));
    return r;
  endfunction

  // Monitor: an output is consumed at the next posedge when valid & ready at the negedge.
  always @(negedge clk) begin
    res_t got, e;
    if (!rst || flush) exp_q.delete();
    else if (out_valid && out_ready) begin
      n_out++;
      got.diff = diff; got.bout = bout; got.zero = zero; got.ovf = ovf;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL spurious_result: got diff %0h, expected no output", diff);
      end else begin
        e = exp_q.pop_front();
        chk("result{diff,bout,zero,ovf}", 32'(got), 32'(e));
      end
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input res_t e);
    int n = 0;
    a = x; b = y; bin = c; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout: in_ready 0, expected 1");
    end else exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic sendm(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    send(x, y, c, model(x, y, c));
  endtask

  task automatic sendr();
    logic [W-1:0] x, y;
    logic         c;
    x = W'($urandom_range(0, 255));
    y = W'($urandom_range(0, 255));
    c = 1'($urandom_range(0, 1));
    sendm(x, y, c);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk({nm, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc, n0, cnt;
    logic stable;
    logic [W-1:0] snap;
    logic         any_out;

    // Reset state
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_outputs", {diff, bout, zero, ovf}, 0);
    #12 rst = 1'b1;
    @(posedge clk); #1;

    // 1: single op, latency
    send(8'h05, 8'h03, 1'b0, '{diff: 8'h02, bout: 1'b0, zero: 1'b0, ovf: 1'b0});
    cyc = 0;
    while (!out_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("latency_edges_after_accept", cyc, W - 1);
    drain("t1");

    // 2: directed borrow, overflow, zero
    send(8'h03, 8'h05, 1'b1, '{diff: 8'hFD, bout: 1'b1, zero: 1'b0, ovf: 1'b0});
    send(8'h80, 8'h01, 1'b0, '{diff: 8'h7F, bout: 1'b0, zero: 1'b0, ovf: 1'b1});
    send(8'h10, 8'h10, 1'b0, '{diff: 8'h00, bout: 1'b0, zero: 1'b1, ovf: 1'b0});
    send(8'h00, 8'h01, 1'b0, '{diff: 8'hFF, bout: 1'b1, zero: 1'b0, ovf: 1'b0});
    drain("t2");

    // 3: 20 back-to-back random ops, results on consecutive cycles
    fork
      begin
        for (int i = 0; i < 20; i++) sendr();
      end
      begin
        int w = 0;
        while (!out_valid && w < 50) begin @(posedge clk); #1; w++; end
        cnt = 0;
        while (out_valid && cnt < 40) begin cnt++; @(posedge clk); #1; end
      end
    join
    chk("burst_consecutive_results", cnt, 20);
    drain("t3");

    // 4: fill with out_ready low, hold 5 cycles, then release
    out_ready = 1'b0;
    n0 = n_out;
    for (int i = 0; i < W; i++) sendr();
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    snap = diff;
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (diff !== snap || !out_valid || in_ready) stable = 1'b0;
    end
    chk("stall_stable", stable, 1);
    out_ready = 1'b1;
    drain("t4");
    chk("stall_drain_count", n_out - n0, W);

    // 5: gapped inputs while stalled: bubbles collapse to hold W ops
    out_ready = 1'b0;
    n0 = n_out;
    for (int i = 0; i < W; i++) begin
      sendr();
      repeat (2) begin @(posedge clk); #1; end
    end
    chk("bubble_full_in_ready", in_ready, 0);
    a = 8'h11; b = 8'h22; bin = 1'b0; in_valid = 1'b1;
    cnt = 0;
    repeat (3) begin @(negedge clk); if (in_ready) cnt++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bubble_extra_rejected", cnt, 0);
    out_ready = 1'b1;
    drain("t5");
    chk("bubble_drain_count", n_out - n0, W);

    // 6a: async reset with 4 ops in flight
    for (int i = 0; i < 4; i++) sendr();
    #2 rst = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_outputs", {diff, bout, zero, ovf}, 0);
    chk("async_rst_in_ready", in_ready, 1);
    n0 = n_out;
    @(negedge clk); #2 rst = 1'b1;
    any_out = 1'b0;
    repeat (15) begin @(posedge clk); #1; if (out_valid) any_out = 1'b1; end
    chk("no_stale_after_reset", any_out, 0);
    chk("reset_no_results", n_out - n0, 0);

    // 6b: flush with 3 ops in flight; input presented during flush is dropped
    for (int i = 0; i < 3; i++) sendr();
    flush = 1'b1; in_valid = 1'b1; a = 8'h55; b = 8'h11; bin = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    n0 = n_out;
    any_out = 1'b0;
    repeat (15) begin @(posedge clk); #1; if (out_valid) any_out = 1'b1; end
    chk("no_result_after_flush", any_out, 0);
    chk("flush_no_results", n_out - n0, 0);

    // Pipe still works after flush
    send(8'h20, 8'h01, 1'b1, '{diff: 8'h1E, bout: 1'b0, zero: 1'b0, ovf: 1'b0});
    drain("post_flush");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
